// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame constants, common command codes.
package ps2_pkg;

  localparam int unsigned BITS_PER_FRAME = 11;
  localparam int unsigned ACK_EDGE       = 11;
  localparam int unsigned EDGE_CNT_W     = 4;
  // Host-to-device payload shifted out after the start bit: data[7:0], parity, stop.
  localparam int unsigned SHIFT_W        = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_BITS    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_state_e;

  // PS/2 uses odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Three-flop synchronisers for the PS/2 clock and data lines plus a falling-edge strobe.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_c_o
);

  logic [2:0] clk_q;
  logic [2:0] data_q;

  // Shift chains; reset to 1 so an idle bus is seen straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q  <= 3'b111;
      data_q <= 3'b111;
    end else begin
      clk_q  <= {clk_q[1:0], ps2_clk_i};
      data_q <= {data_q[1:0], ps2_data_i};
    end
  end

  assign clk_s_o      = clk_q[2];
  assign data_s_o     = data_q[2];
  assign clk_fall_c_o = ~clk_q[1] & clk_q[2];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter with inhibit, ACK check and inter-edge timeout.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0]      INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [EDGE_CNT_W-1:0] STOP_EDGE    = EDGE_CNT_W'(BITS_PER_FRAME - 1);
  localparam logic [EDGE_CNT_W-1:0] ACK_EDGE_CNT = EDGE_CNT_W'(ACK_EDGE);

  ps2_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [EDGE_CNT_W-1:0]  edge_q, edge_d, edge_inc_c;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic                   ack_err_q, ack_err_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   tx_done_q, tx_done_d;
  logic                   tx_error_q, tx_error_d;
  logic                   clk_s, data_s, clk_fall_c;
  logic                   timed_c, shift_c, finish_c, abort_c;

  ps2_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .clk_s_o      (clk_s),
    .data_s_o     (data_s),
    .clk_fall_c_o (clk_fall_c)
  );

  assign timed_c    = (state_q == ST_START) || (state_q == ST_BITS) ||
                      (state_q == ST_ACK)   || (state_q == ST_RELEASE);
  assign edge_inc_c = (edge_q >= ACK_EDGE_CNT) ? edge_q : edge_q + EDGE_CNT_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      shift_q    <= '0;
      ack_err_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      shift_q    <= shift_d;
      ack_err_q  <= ack_err_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  // Next-state, frame sequencing and timeout supervision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    shift_c   = 1'b0;
    finish_c  = 1'b0;
    abort_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d   = ST_INHIBIT;
          cnt_d     = '0;
          edge_d    = '0;
          shift_d   = {1'b1, odd_parity(tx_data), tx_data};
          ack_err_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d = ST_START;
          cnt_d   = '0;
          edge_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START, ST_BITS: begin
        if (clk_fall_c) begin
          shift_c = 1'b1;
          shift_d = shift_q >> 1;
          edge_d  = edge_inc_c;
          state_d = (edge_inc_c == STOP_EDGE) ? ST_ACK : ST_BITS;
        end
      end
      ST_ACK: begin
        if (clk_fall_c && (edge_inc_c == ACK_EDGE_CNT)) begin
          ack_err_d = data_s;
          edge_d    = edge_inc_c;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (clk_s && data_s) begin
          finish_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Device must keep clocking; any gap of TIMEOUT_CYCLES abandons the frame.
    if (timed_c && !finish_c) begin
      if (clk_fall_c) begin
        cnt_d = '0;
      end else if (cnt_q == TIMEOUT_LAST) begin
        abort_c = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (finish_c || abort_c) begin
      cnt_d  = '0;
      edge_d = '0;
    end
  end

  // Output decode, registered alongside the state.
  always_comb begin
    clk_oe_d   = (state_d == ST_INHIBIT);
    data_oe_d  = 1'b0;
    tx_done_d  = finish_c | abort_c;
    tx_error_d = abort_c | (finish_c & ack_err_q);
    // Ready stays low on the done cycle so a waiting request starts one cycle later.
    tx_ready_d = (state_d == ST_IDLE) & ~tx_done_d;
    case (state_d)
      ST_INHIBIT:     data_oe_d = (cnt_d == INHIBIT_LAST);
      ST_START:       data_oe_d = 1'b1;
      ST_BITS, ST_ACK: data_oe_d = shift_c ? ~shift_q[0] : data_oe_q;
      default:        data_oe_d = 1'b0;
    endcase
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Randomised self-checking bench for ps2_tx with a wired-AND bus and a behavioural device.
module tb_ps2_tx;

  localparam int INH = 20;
  localparam int TMO = 5000;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_RESET  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_done, tx_error;
  logic       dev_clk, dev_data;
  logic       ps2_clk_w, ps2_data_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state for the per-cycle compare process.
  bit active   = 1'b0;
  bit rst_prev = 1'b0;
  int c        = 0;
  int done_cnt = 0;
  int exp_mode = M_ACK;
  bit exp_err  = 1'b0;

  assign ps2_clk_w  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_w = dev_data & ~ps2_data_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk_w),
    .ps2_data    (ps2_data_w),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line values a device must see after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Per-cycle compare: frame timeline counted from the accepting cycle.
  always @(negedge clk) begin
    if (rst) begin
      active   = 1'b0;
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        check("rst_ready", int'(tx_ready), 1);
        check("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check("rst_done_err", int'({tx_done, tx_error}), 0);
      end
      rst_prev = 1'b0;
      if (active) begin
        c++;
        check("busy_ready", int'(tx_ready), 0);
        if (c <= INH) begin
          check("inhibit_clk_oe", int'(ps2_clk_oe), 1);
          check("inhibit_data_oe", int'(ps2_data_oe), int'(c == INH));
        end else if (c == INH + 1) begin
          check("start_clk_oe", int'(ps2_clk_oe), 0);
          check("start_data_oe", int'(ps2_data_oe), 1);
        end else begin
          check("frame_clk_oe", int'(ps2_clk_oe), 0);
        end
        if (tx_done) begin
          done_cnt++;
          check("done_error", int'(tx_error), int'(exp_err));
          check("done_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
          if (exp_mode == M_SILENT) check("timeout_cycle", c, INH + 1 + TMO);
          active = 1'b0;
        end else begin
          check("error_without_done", int'(tx_error), 0);
        end
      end else begin
        check("idle_ready", int'(tx_ready), 1);
        check("idle_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check("idle_done_err", int'({tx_done, tx_error}), 0);
        if (tx_valid && tx_ready) begin
          active = 1'b1;
          c      = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] d);
    int w = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("request_accept", int'(tx_ready), 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Behavioural PS/2 device: clocks the frame, samples each host bit mid-high, answers ACK.
  task automatic device_frame(input int mode, input int half, output logic [9:0] bits);
    int w = 0;
    bits     = '0;
    exp_mode = mode;
    exp_err  = (mode != M_ACK);
    while (!(ps2_clk_w == 1'b1 && ps2_data_w == 1'b0) && w < 4 * INH + 100) begin
      step(1);
      w++;
    end
    check("start_condition", int'(w < 4 * INH + 100), 1);
    if (mode == M_SILENT) return;
    step(half);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      step(half);
      dev_clk = 1'b1;
      step(half / 2);
      if (k <= 10) bits[k-1] = ps2_data_w;
      if (k == 10 && mode == M_ACK) dev_data = 1'b0;
      if (k == 5 && mode == M_RESET) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        return;
      end
      step(half - half / 2);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int w = 0;
    while (done_cnt == d0 && w < limit) begin
      @(posedge clk);
      w++;
    end
    check("done_seen", int'(done_cnt != d0), 1);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int mode, input int half,
                      output logic [9:0] bits);
    int d0;
    d0 = done_cnt;
    request(d);
    device_frame(mode, half, bits);
    if (mode == M_ACK || mode == M_NOACK) check("frame_bits", int'(bits), int'(frame_model(d)));
    if (mode != M_RESET) wait_done(d0, TMO + INH + 30 * half + 200);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    int         d0, mode, half;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    step(4);
    rst = 1'b0;
    step(5);

    // Hand-computed frames pin the model's bit order and parity.
    send(8'hED, M_ACK, 40, bits);
    check("lit_0xED", int'(bits), int'(10'h3ED));
    send(8'h01, M_ACK, 30, bits);
    check("lit_0x01", int'(bits), int'(10'h201));
    send(8'hFF, M_ACK, 25, bits);
    check("lit_0xFF", int'(bits), int'(10'h3FF));
    send(8'h00, M_ACK, 35, bits);
    check("lit_0x00", int'(bits), int'(10'h300));

    // Silent device, then missing ACK.
    send(8'hA5, M_SILENT, 40, bits);
    step(3);
    send(8'h3C, M_NOACK, 30, bits);
    step(3);

    // Reset mid-frame must not produce a completion; next command runs normally.
    d0 = done_cnt;
    send(8'hF4, M_RESET, 30, bits);
    step(50);
    check("reset_no_done", done_cnt, d0);
    send(8'hF4, M_ACK, 30, bits);

    // tx_valid held high: back-to-back frames, each with its own inhibit.
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      d0 = done_cnt;
      device_frame(M_ACK, 20, bits);
      check("b2b_bits", int'(bits), int'(frame_model(8'hF4)));
      if (f == 2) wait_done(d0, 2000);
      else        wait_done(d0, 2000);
      if (f == 2) tx_valid = 1'b0;
    end
    step(5);

    // Randomised commands, device speeds and ACK behaviour.
    for (int r = 0; r < 8; r++) begin
      d    = 8'($urandom);
      mode = ($urandom_range(0, 9) < 8) ? M_ACK : M_NOACK;
      half = $urandom_range(10, 50);
      send(d, mode, half, bits);
      step($urandom_range(1, 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
